// File: rtl/rggen_bit_field_if.sv
// rtl/rggen_bit_field_if.sv - bit field access interface between register logic (master) and a field (slave)
interface rggen_bit_field_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  read_access;
  logic                  write_access;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] write_mask;
  logic [DATA_WIDTH-1:0] read_data;
  logic [DATA_WIDTH-1:0] value;

  modport master (
    output read_access, write_access, write_data, write_mask,
    input  read_data, value
  );

  modport slave (
    input  read_access, write_access, write_data, write_mask,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_event_counter.sv
// rtl/rggen_bit_field_event_counter.sv - saturating hardware event counter bit field with sticky overflow and match pulse
// Optional RGGEN_EVENT_COUNTER_CLEAR_ON_READ_EN: a read without a write clears the counter.
module rggen_bit_field_event_counter #(
  parameter int               WIDTH         = 16,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter logic [WIDTH-1:0] MATCH_VALUE   = '1
)(
  input  logic                clk,
  input  logic                rst,
  rggen_bit_field_if.slave    bit_field_if,
  input  logic                i_event,
  input  logic                i_enable,
  input  logic                i_clear,
  output logic [WIDTH-1:0]    o_count,
  output logic                o_overflow,
  output logic                o_match
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             overflow_q;
  logic             overflow_d;
  logic             match_q;
  logic             match_d;
  logic             inc;
  logic             all_ones;
  logic [WIDTH-1:0] count_plus_one;

  assign inc            = i_event & i_enable;
  assign all_ones       = &count_q;
  assign count_plus_one = count_q + {{(WIDTH-1){1'b0}}, 1'b1};

`ifndef RGGEN_EVENT_COUNTER_CLEAR_ON_READ_EN
  logic unused_read_access;
  assign unused_read_access = bit_field_if.read_access;
`endif

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    match_d    = 1'b0;
    if (i_clear) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (bit_field_if.write_access) begin
      count_d    = (count_q & ~bit_field_if.write_mask) |
                   (bit_field_if.write_data & bit_field_if.write_mask);
      overflow_d = 1'b0;
`ifdef RGGEN_EVENT_COUNTER_CLEAR_ON_READ_EN
    end else if (bit_field_if.read_access) begin
      // The event arriving with the read is counted into the fresh value.
      count_d    = {{(WIDTH-1){1'b0}}, inc};
      overflow_d = 1'b0;
`endif
    end else if (inc) begin
      if (!all_ones) begin
        count_d = count_plus_one;
        match_d = (count_plus_one == MATCH_VALUE);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= INITIAL_VALUE;
      overflow_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      match_q    <= match_d;
    end
  end

  assign o_count                = count_q;
  assign o_overflow             = overflow_q;
  assign o_match                = match_q;
  assign bit_field_if.read_data = count_q;
  assign bit_field_if.value     = count_q;
endmodule
